// File: rtl/ball_pkg.sv
// Shared constants and types for the ball motion controller and its matcher.
package ball_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Row Y coordinates; the row stop matcher uses the same values.
  localparam coord_t ROW1 = 10'd110;
  localparam coord_t ROW2 = 10'd180;
  localparam coord_t ROW3 = 10'd250;
  localparam coord_t ROW4 = 10'd320;
  localparam coord_t ROW5 = 10'd390;

  localparam coord_t START_X = 10'd320;
  localparam coord_t START_Y = 10'd0;
  localparam coord_t FLOOR_Y = 10'd460;
  localparam coord_t STEP_Y  = 10'd2;
  localparam coord_t STEP_X  = 10'd1;
  localparam coord_t X_MAX   = 10'd639;

  // Clocks spent at a row before stopX is trusted (matcher latency 1 + margin).
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned SETTLE_W   = 2;
  typedef logic [SETTLE_W-1:0] settle_t;
  localparam settle_t SETTLE_LAST = settle_t'(SETTLE_CYC - 1);

  localparam logic [2:0] ROWS_MAX = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FALL,
    ST_SETTLE,
    ST_ROLL,
    ST_DONE
  } state_t;

  // True when an 11-bit candidate Y lands exactly on one of the rows.
  function automatic logic is_row(input logic [COORD_W:0] y);
    return (y == {1'b0, ROW1}) || (y == {1'b0, ROW2}) || (y == {1'b0, ROW3}) ||
           (y == {1'b0, ROW4}) || (y == {1'b0, ROW5});
  endfunction

endpackage

// File: rtl/ball_step.sv
// One horizontal roll step: move toward the target by STEP_X, snapping when closer.
module ball_step
  import ball_pkg::*;
(
  input  logic [COORD_W-1:0] i_ball_x,
  input  logic [COORD_W-1:0] i_target,
  output logic [COORD_W-1:0] o_next_x
);

  logic [COORD_W-1:0] w_diff;

  // Direction and distance to target decide a full step or a snap.
  // NOTE: every branch assigns both outputs so no latch is inferred.
  always_comb begin
    if (i_ball_x < i_target) begin
      w_diff   = i_target - i_ball_x;
      o_next_x = (w_diff < STEP_X) ? i_target : i_ball_x + STEP_X;
    end else begin
      w_diff   = i_ball_x - i_target;
      o_next_x = (w_diff < STEP_X) ? i_target : i_ball_x - STEP_X;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball motion controller: fall, settle at each row, roll to stopX, repeat to floor.
module ball_motion_ctrl
  import ball_pkg::*;
(
  input  logic               MAX10_CLK1_50,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [COORD_W-1:0] stopX,
  output logic [COORD_W-1:0] BallX,
  output logic [COORD_W-1:0] BallY,
  output logic [2:0]         rows_passed,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  coord_t             r_stop_x_q;
  settle_t            r_settle_cnt;

  logic [COORD_W:0]   w_ny;
  coord_t             w_next_x;
  coord_t             w_stop_clamped;
  logic [2:0]         w_rows_inc;

  // Extra bit keeps the floor compare honest near the top of the range.
  assign w_ny           = {1'b0, BallY} + {1'b0, STEP_Y};
  assign w_stop_clamped = (stopX > X_MAX) ? X_MAX : stopX;
  assign w_rows_inc     = (rows_passed == ROWS_MAX) ? ROWS_MAX : rows_passed + 3'd1;

  ball_step u_step (
    .i_ball_x (BallX),
    .i_target (r_stop_x_q),
    .o_next_x (w_next_x)
  );

  // Motion FSM with all outputs registered alongside the state.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      BallX        <= START_X;
      BallY        <= START_Y;
      rows_passed  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      r_stop_x_q   <= '0;
      r_settle_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            BallX       <= START_X;
            BallY       <= START_Y;
            rows_passed <= '0;
            r_state     <= ST_FALL;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end

        ST_FALL: begin
          if (frame_tick) begin
            if (w_ny >= {1'b0, FLOOR_Y}) begin
              BallY   <= FLOOR_Y;
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              BallY <= w_ny[COORD_W-1:0];
              if (is_row(w_ny)) begin
                r_settle_cnt <= '0;
                r_state      <= ST_SETTLE;
              end
            end
          end
        end

        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            r_stop_x_q <= w_stop_clamped;
            r_state    <= ST_ROLL;
          end else begin
            r_settle_cnt <= r_settle_cnt + settle_t'(1);
          end
        end

        ST_ROLL: begin
          if (frame_tick) begin
            if (BallX == r_stop_x_q) begin
              // Leave the row on this tick so the same row cannot re-trigger.
              rows_passed <= w_rows_inc;
              BallY       <= BallY + STEP_Y;
              r_state     <= ST_FALL;
            end else begin
              BallX <= w_next_x;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Self-checking bench for ball_motion_ctrl with a behavioural model and a matcher stand-in.
module tb_ball_motion_ctrl;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] stopX = '0;
  logic [9:0] BallX, BallY;
  logic [2:0] rows_passed;
  logic       busy, done;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  ball_motion_ctrl dut (
    .MAX10_CLK1_50 (clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .start         (start),
    .stopX         (stopX),
    .BallX         (BallX),
    .BallY         (BallY),
    .rows_passed   (rows_passed),
    .busy          (busy),
    .done          (done)
  );

  always #10 clk = ~clk;

  // Scenario constants, restated from the block's behaviour
  localparam int START_X = 320, START_Y = 0, FLOOR_Y = 460;
  localparam int STEP_X = 1, STEP_Y = 2, X_MAX = 639, SETTLE_CYC = 2;
  localparam int M_IDLE = 0, M_FALL = 1, M_SETTLE = 2, M_ROLL = 3, M_DONE = 4;

  int rows_y [5] = '{110, 180, 250, 320, 390};
  int tgt    [5] = '{0, 0, 0, 0, 0};

  typedef struct {
    int x;
    int y;
    int rows;
    int phase;
    int wait_left;
    int target;
  } model_t;

  model_t m;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit on_row(input int y);
    foreach (rows_y[k]) if (rows_y[k] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r.x = START_X; r.y = START_Y; r.rows = 0; r.phase = M_IDLE;
    r.wait_left = 0; r.target = 0;
    return r;
  endfunction

  // One clock of the intended behaviour, phrased as ball physics
  function automatic model_t model_next(input model_t cur, input bit st, input bit tk, input int sx);
    model_t n = cur;
    int d;
    case (cur.phase)
      M_IDLE, M_DONE:
        if (st) begin
          n.x = START_X; n.y = START_Y; n.rows = 0; n.phase = M_FALL;
        end
      M_FALL:
        if (tk) begin
          if (cur.y + STEP_Y >= FLOOR_Y) begin
            n.y = FLOOR_Y; n.phase = M_DONE;
          end else begin
            n.y = cur.y + STEP_Y;
            if (on_row(n.y)) begin
              n.phase = M_SETTLE; n.wait_left = SETTLE_CYC;
            end
          end
        end
      M_SETTLE: begin
        n.wait_left = cur.wait_left - 1;
        if (n.wait_left == 0) begin
          n.target = (sx > X_MAX) ? X_MAX : sx;
          n.phase  = M_ROLL;
        end
      end
      M_ROLL:
        if (tk) begin
          d = cur.target - cur.x;
          if (d == 0) begin
            n.rows  = (cur.rows >= 5) ? 5 : cur.rows + 1;
            n.y     = cur.y + STEP_Y;
            n.phase = M_FALL;
          end else if (d > 0) begin
            n.x = cur.x + ((d < STEP_X) ? d : STEP_X);
          end else begin
            n.x = cur.x - ((-d < STEP_X) ? -d : STEP_X);
          end
        end
      default: n = model_reset();
    endcase
    return n;
  endfunction

  // Model advances on the same edges and reset as the DUT
  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) m <= model_reset();
    else          m <= model_next(m, start, frame_tick, int'(stopX));
  end

  // Row stop matcher stand-in: registered stopX one clock after BallY hits a row
  always @(negedge clk) begin
    foreach (rows_y[k]) if (int'(BallY) == rows_y[k]) stopX = 10'(tgt[k]);
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp BallX", int'(BallX), m.x);
      check("cmp BallY", int'(BallY), m.y);
      check("cmp rows_passed", int'(rows_passed), m.rows);
      check("cmp busy", int'(busy), int'(m.phase inside {M_FALL, M_SETTLE, M_ROLL}));
      check("cmp done", int'(done), int'(m.phase == M_DONE));
    end
  end

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 Reset_n = 1'b0;
    clocks(2);
    Reset_n = 1'b1;
  endtask

  task automatic check_pos(input string name, input int x, input int y, input int rows);
    check({name, " X"}, int'(BallX), x);
    check({name, " Y"}, int'(BallY), y);
    check({name, " rows"}, int'(rows_passed), rows);
  endtask

  initial begin
    #1 Reset_n = 1'b0;
    clocks(2);
    check_pos("reset", 320, 0, 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    Reset_n = 1'b1;
    cmp_en = 1'b1;

    // Drop to row 1 with stopX=200
    tgt = '{200, 0, 0, 0, 0};
    pulse_start();
    ticks(55);
    check_pos("row1 arrive", 320, 110, 0);
    check("row1 busy", int'(busy), 1);
    clocks(3);
    ticks(120);
    check_pos("row1 rolled", 200, 110, 0);
    tick();
    check_pos("row1 leave", 200, 112, 1);

    // Zero-length roll at row 1
    do_reset();
    tgt = '{320, 330, 0, 0, 0};
    pulse_start();
    ticks(55);
    clocks(3);
    tick();
    check_pos("zero roll", 320, 112, 1);

    // Tick and start during SETTLE at row 2, then start while rolling
    ticks(34);
    check_pos("row2 arrive", 320, 180, 1);
    @(negedge clk) begin frame_tick = 1'b1; start = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; start = 1'b0; end
    check_pos("settle ignore", 320, 180, 1);
    clocks(2);
    pulse_start();
    check_pos("start busy", 320, 180, 1);
    check("start busy flag", int'(busy), 1);
    ticks(5);
    check_pos("row2 rolling", 325, 180, 1);

    // Asynchronous reset mid-roll takes effect before any clock edge
    @(negedge clk);
    #3 Reset_n = 1'b0;
    #1;
    check_pos("async reset", 320, 0, 0);
    check("async reset busy", int'(busy), 0);
    clocks(2);
    Reset_n = 1'b1;

    // Out-of-range stopX clamps to X_MAX
    tgt = '{700, 0, 0, 0, 0};
    pulse_start();
    ticks(55);
    clocks(3);
    ticks(319);
    check_pos("clamp reach", 639, 110, 0);
    tick();
    check_pos("clamp leave", 639, 112, 1);

    // Full drop to the floor
    do_reset();
    tgt = '{300, 340, 310, 320, 330};
    pulse_start();
    for (int i = 0; i < 1500 && !done; i++) tick();
    check_pos("floor", 330, 460, 5);
    check("floor done", int'(done), 1);
    check("floor busy", int'(busy), 0);
    tick();
    check_pos("done hold", 330, 460, 5);

    // Restart from DONE with tick in the same clock: start wins
    @(negedge clk) begin frame_tick = 1'b1; start = 1'b1; end
    @(negedge clk) begin frame_tick = 1'b0; start = 1'b0; end
    check_pos("restart", 320, 0, 0);
    check("restart busy", int'(busy), 1);
    check("restart done", int'(done), 0);
    tick();
    check_pos("restart fall", 320, 2, 0);

    clocks(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
